// File: rtl/keycode_event_decoder.sv
// keycode_event_decoder
//   Turns the raw 8-bit USB HID keycode coming from the SoC PIO into game key
//   state. The keycode is glitch-filtered, and every accepted change becomes
//   release/press events. The module keeps a bitmap of eight held game keys,
//   drives one-cycle press/release pulses, and queues the events in a
//   first-word-fallthrough FIFO.
//
// Ports
//   clk            system clock
//   reset_n        synchronous active-low reset
//   keycode_in     HID keycode, 0x00 = no key
//   held           held bitmap: [0]W [1]A [2]D [3]Space [4]Up [5]Left [6]Right [7]Enter
//   press_pulse    one-cycle pulse per tracked key on press
//   release_pulse  one-cycle pulse per tracked key on release
//   evt_valid      FIFO non-empty
//   evt_data       head event {is_press, keycode}
//   evt_ready      consumer pop (effective only while evt_valid)
//   evt_count      FIFO occupancy
//   overflow       sticky, set when an event is dropped on a full FIFO
//   ovf_clr        clears overflow; a simultaneous set wins
module keycode_event_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    keycode_in,
  output logic [7:0]                    held,
  output logic [7:0]                    press_pulse,
  output logic [7:0]                    release_pulse,
  output logic                          evt_valid,
  output logic [8:0]                    evt_data,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0]    STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EMIT_REL   = 2'd1,
    EMIT_PRESS = 2'd2
  } state_t;

  // Map a keycode to its held-bitmap bit; untracked codes map to zero.
  function automatic logic [7:0] key_onehot(input logic [7:0] code);
    logic [7:0] bits;
    case (code)
      8'h1A:   bits = 8'b0000_0001;
      8'h04:   bits = 8'b0000_0010;
      8'h07:   bits = 8'b0000_0100;
      8'h2C:   bits = 8'b0000_1000;
      8'h52:   bits = 8'b0001_0000;
      8'h50:   bits = 8'b0010_0000;
      8'h4F:   bits = 8'b0100_0000;
      8'h28:   bits = 8'b1000_0000;
      default: bits = 8'b0000_0000;
    endcase
    return bits;
  endfunction

  logic [7:0]    key_q;
  logic [7:0]    cand;
  logic [7:0]    cnt;
  logic [7:0]    cand_next;
  logic [7:0]    cnt_next;
  logic          change_ready;
  logic [7:0]    accepted;
  logic [7:0]    old_code;
  logic [7:0]    new_code;
  state_t        state;
  logic          wr_en;
  logic [8:0]    wr_data;
  logic          rd_do;
  logic          wr_do;
  logic          drop;
  logic          full;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Next candidate/counter values of the stability filter. Acceptance looks at
  // the post-edge values, so a code presented at edge t is taken at edge
  // t+STABLE_CYCLES. A saturated counter keeps a pending change alive while
  // the FSM is busy emitting.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (key_q != cand) begin
      cand_next = key_q;
      cnt_next  = 8'd1;
    end else if (cnt < STABLE_MAX) begin
      cnt_next = cnt + 8'd1;
    end else begin
      cnt_next = cnt;
    end
    change_ready = (cnt_next == STABLE_MAX) && (cand_next != accepted);
  end

  // Input register and stability filter state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_q <= 8'h00;
      cand  <= 8'h00;
      cnt   <= 8'd0;
    end else begin
      key_q <= keycode_in;
      cand  <= cand_next;
      cnt   <= cnt_next;
    end
  end

  // Event generation: the FSM writes one FIFO entry per EMIT_* cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = 9'h000;
    case (state)
      EMIT_REL: begin
        wr_en   = 1'b1;
        wr_data = {1'b0, old_code};
      end
      EMIT_PRESS: begin
        wr_en   = 1'b1;
        wr_data = {1'b1, new_code};
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = 9'h000;
      end
    endcase
  end

  // Key-state FSM: accepts changes in IDLE, then emits release and/or press.
  // press_pulse is registered on entry to EMIT_PRESS so it is high during it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      accepted      <= 8'h00;
      old_code      <= 8'h00;
      new_code      <= 8'h00;
      held          <= 8'h00;
      press_pulse   <= 8'h00;
      release_pulse <= 8'h00;
    end else begin
      press_pulse   <= 8'h00;
      release_pulse <= 8'h00;
      case (state)
        IDLE: begin
          if (change_ready) begin
            accepted      <= cand_next;
            old_code      <= accepted;
            new_code      <= cand_next;
            held          <= (held & ~key_onehot(accepted)) | key_onehot(cand_next);
            release_pulse <= key_onehot(accepted);
            if (accepted != 8'h00) begin
              state <= EMIT_REL;
            end else if (cand_next != 8'h00) begin
              state       <= EMIT_PRESS;
              press_pulse <= key_onehot(cand_next);
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        EMIT_REL: begin
          if (new_code != 8'h00) begin
            state       <= EMIT_PRESS;
            press_pulse <= key_onehot(new_code);
          end else begin
            state <= IDLE;
          end
        end
        EMIT_PRESS: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign full      = (evt_count == DEPTH_C);
  assign evt_valid = (evt_count != {CW{1'b0}});
  assign evt_data  = mem[rd_ptr];
  // A pop frees a slot in the same cycle, so a write on a full FIFO still
  // lands when the consumer is popping.
  assign rd_do     = evt_valid & evt_ready;
  assign wr_do     = wr_en & (~full | rd_do);
  assign drop      = wr_en & full & ~rd_do;

  // Event FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 9'h000;
      end
      wr_ptr    <= {PW{1'b0}};
      rd_ptr    <= {PW{1'b0}};
      evt_count <= {CW{1'b0}};
      overflow  <= 1'b0;
    end else begin
      if (wr_do) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_do) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_do, rd_do})
        2'b10:   evt_count <= evt_count + CW'(1);
        2'b01:   evt_count <= evt_count - CW'(1);
        default: evt_count <= evt_count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Testbench for keycode_event_decoder: directed scenarios followed by random
// keycode streams, every cycle compared with an event-level reference model.
module tb_keycode_event_decoder;

  localparam int S = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] keycode_in;
  logic [7:0] held;
  logic [7:0] press_pulse;
  logic [7:0] release_pulse;
  logic       evt_valid;
  logic [8:0] evt_data;
  logic       evt_ready;
  logic [3:0] evt_count;
  logic       overflow;
  logic       ovf_clr;

  always #5 clk = ~clk;

  keycode_event_decoder #(.STABLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .keycode_in(keycode_in),
    .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .evt_count(evt_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] tracked [8] = '{8'h1A, 8'h04, 8'h07, 8'h2C, 8'h52, 8'h50, 8'h4F, 8'h28};
  logic [7:0] pool [10]   = '{8'h00, 8'h00, 8'h1A, 8'h04, 8'h4F, 8'h28, 8'h05, 8'h39, 8'h2C, 8'h52};

  // Reference model state: the accepted key, the run of identical input
  // samples, scheduled FIFO writes and the expected FIFO contents.
  typedef struct {
    int         edge_n;
    logic [8:0] data;
  } wr_t;

  int         ecount = 0;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_last = 8'h00;
  int         m_run = 1;
  int         m_next_free = 0;
  wr_t        m_sched [$];
  logic [8:0] m_fifo [$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_rel = 8'h00;
  int         m_press_edge = -1;
  logic [7:0] m_press_val = 8'h00;

  function automatic logic [7:0] onehot(input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (c != 8'h00 && tracked[i] == c) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic       pop;
    logic       wr;
    logic [8:0] wd;
    logic [7:0] old_c;
    logic [7:0] new_c;
    int         k;
    wr_t        w;
    if (!reset_n) begin
      m_acc = 8'h00; m_last = 8'h00; m_run = 1; m_next_free = 0;
      m_sched.delete(); m_fifo.delete();
      m_ovf = 1'b0; m_rel = 8'h00; m_press_edge = -1; m_press_val = 8'h00;
      return;
    end
    pop = (m_fifo.size() != 0) && evt_ready;
    wr  = 1'b0;
    wd  = 9'h000;
    if (m_sched.size() != 0 && m_sched[0].edge_n == ecount) begin
      w  = m_sched.pop_front();
      wr = 1'b1;
      wd = w.data;
    end
    m_rel = 8'h00;
    // A change is taken once S identical samples precede this edge and the
    // previous change has finished emitting its events.
    if (ecount >= m_next_free && m_run >= S && m_last != m_acc) begin
      old_c = m_acc;
      new_c = m_last;
      m_rel = onehot(old_c);
      k = ecount + 1;
      if (old_c != 8'h00) begin
        w.edge_n = k; w.data = {1'b0, old_c};
        m_sched.push_back(w);
        k++;
      end
      if (new_c != 8'h00) begin
        w.edge_n = k; w.data = {1'b1, new_c};
        m_sched.push_back(w);
        m_press_edge = k - 1;
        m_press_val  = onehot(new_c);
      end
      m_next_free = k;
      m_acc = new_c;
    end
    if (pop) void'(m_fifo.pop_front());
    if (wr && m_fifo.size() >= D) m_ovf = 1'b1;
    else begin
      if (wr) m_fifo.push_back(wd);
      if (ovf_clr) m_ovf = 1'b0;
    end
    if (keycode_in == m_last) begin
      if (m_run < 255) m_run++;
    end else begin
      m_last = keycode_in;
      m_run  = 1;
    end
  endtask

  task automatic compare();
    chk("held", {8'h00, held}, {8'h00, onehot(m_acc)});
    chk("press_pulse", {8'h00, press_pulse},
        {8'h00, (ecount == m_press_edge) ? m_press_val : 8'h00});
    chk("release_pulse", {8'h00, release_pulse}, {8'h00, m_rel});
    chk("evt_valid", {15'h0, evt_valid}, {15'h0, m_fifo.size() != 0});
    chk("evt_count", {12'h0, evt_count}, 16'(m_fifo.size()));
    chk("overflow", {15'h0, overflow}, {15'h0, m_ovf});
    if (m_fifo.size() != 0) chk("evt_data", {7'h0, evt_data}, {7'h0, m_fifo[0]});
  endtask

  // One clock edge: inputs are stable from the previous falling edge, the model
  // advances at the rising edge and outputs are compared at the falling edge.
  task automatic step();
    @(posedge clk);
    ecount++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic hold(input logic [7:0] code, input int n);
    keycode_in = code;
    repeat (n) step();
  endtask

  initial begin
    reset_n = 1'b0; keycode_in = 8'h00; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);

    // Reset then idle
    repeat (2) step();
    chk("rst_held", {8'h00, held}, 16'h0000);
    chk("rst_count", {12'h0, evt_count}, 16'h0000);
    chk("rst_valid", {15'h0, evt_valid}, 16'h0000);
    chk("rst_ovf", {15'h0, overflow}, 16'h0000);
    chk("rst_data", {7'h0, evt_data}, 16'h0000);
    reset_n = 1'b1;
    hold(8'h00, 3);

    // Press and release W
    hold(8'h1A, 8);
    chk("w_held", {8'h00, held}, 16'h0001);
    hold(8'h00, 8);
    chk("w_count", {12'h0, evt_count}, 16'h0002);

    // Glitch reject
    hold(8'h2C, 3);
    hold(8'h00, 6);
    chk("glitch_count", {12'h0, evt_count}, 16'h0002);

    // Direct switch A -> Right, then release
    hold(8'h04, 8);
    hold(8'h4F, 8);
    chk("switch_held", {8'h00, held}, 16'h0040);
    hold(8'h00, 8);

    // Fill to overflow: Up press/release, Left press is the ninth event
    hold(8'h52, 8);
    hold(8'h00, 8);
    hold(8'h50, 8);
    chk("ovf_count", {12'h0, evt_count}, 16'h0008);
    chk("ovf_set", {15'h0, overflow}, 16'h0001);
    chk("ovf_head", {7'h0, evt_data}, 16'h011A);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", {15'h0, overflow}, 16'h0000);
    // Release of Left is written on the sixth edge; pop on that same edge
    hold(8'h00, 5);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("full_rw_count", {12'h0, evt_count}, 16'h0008);
    chk("full_rw_ovf", {15'h0, overflow}, 16'h0000);
    step();

    // Drain, then untracked code
    evt_ready = 1'b1;
    repeat (12) step();
    evt_ready = 1'b0;
    hold(8'h05, 8);
    chk("untr_data", {7'h0, evt_data}, 16'h0105);
    chk("untr_held", {8'h00, held}, 16'h0000);
    hold(8'h00, 8);

    // Reset asserted in the EMIT_PRESS cycle
    hold(8'h05, 5);
    reset_n = 1'b0;
    step();
    chk("midrst_count", {12'h0, evt_count}, 16'h0000);
    chk("midrst_valid", {15'h0, evt_valid}, 16'h0000);
    chk("midrst_held", {8'h00, held}, 16'h0000);
    reset_n = 1'b1;
    keycode_in = 8'h00;
    repeat (3) step();

    // Random keycode streams with random consumer back-pressure
    for (int seg = 0; seg < 120; seg++) begin
      keycode_in = pool[$urandom_range(0, 9)];
      for (int c = 0, n = $urandom_range(1, 7); c < n; c++) begin
        evt_ready = ($urandom_range(0, 3) == 0);
        ovf_clr   = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    hold(8'h00, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_event_decoder.md
Name: keycode_event_decoder

Overview:
- Consumes the 8-bit USB HID keycode driven by the SoC keycode PIO and turns it into game-facing key state.
- Glitch-filters the keycode so a value must be stable before it is accepted.
- Maintains a held-key bitmap for the eight tracked game keys and one-cycle press/release pulses.
- Queues every press/release as an event in a small FIFO with a valid/ready read port for the game logic.

Parameters:
STABLE_CYCLES, 4, consecutive cycles keycode_in must hold a value before it is accepted (legal range 1..255)
FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..64)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
keycode_in  input  8  HID keycode from SoC PIO; 0x00 = no key
held  output  8  held bitmap: [0]W 0x1A, [1]A 0x04, [2]D 0x07, [3]Space 0x2C, [4]Up 0x52, [5]Left 0x50, [6]Right 0x4F, [7]Enter 0x28
press_pulse  output  8  one-cycle pulse per tracked key on press
release_pulse  output  8  one-cycle pulse per tracked key on release
evt_valid  output  1  FIFO non-empty
evt_data  output  9  {is_press, keycode[7:0]}; head entry, first-word-fallthrough
evt_ready  input  1  consumer pop; pop occurs when evt_valid & evt_ready
evt_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky; set when an event is dropped because the FIFO is full
ovf_clr  input  1  clears overflow; a set in the same cycle wins

Behaviour:
- Synchronous reset, sampled on the rising edge of clk while reset_n=0.
  - Accepted code is set to 0x00; the candidate and stability counter are cleared.
  - held, press_pulse, release_pulse, evt_count, overflow and evt_valid all reset to 0; evt_data resets to 0.
  - FSM returns to IDLE. A pending event is discarded, including when reset is asserted mid-operation.
- Stability filter:
  - keycode_in is registered every cycle.
  - If the registered value differs from the candidate, the candidate is loaded and the counter is set to 1.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
  - When the counter reaches STABLE_CYCLES and candidate ≠ accepted, a change is accepted.
  - A value first presented at edge t is accepted at edge t+STABLE_CYCLES.
  - Toggling faster than this produces no change.
- FSM states: IDLE, EMIT_REL, EMIT_PRESS.
  - IDLE, on an accepted change old→new: update accepted <= new.
    - If the old code is tracked, clear its held bit and pulse its release_pulse.
    - If the new code is tracked, set its held bit.
    - If old ≠ 0, go to EMIT_REL; else if new ≠ 0, go to EMIT_PRESS; else stay in IDLE.
  - EMIT_REL: write {0, old} to the FIFO. Then go to EMIT_PRESS if new ≠ 0, else IDLE.
  - EMIT_PRESS: write {1, new} to the FIFO, pulse press_pulse for the new code if it is tracked, go to IDLE.
- Timing and ordering:
  - press_pulse fires in the EMIT_PRESS cycle. release_pulse fires on the acceptance edge.
  - The stability filter keeps running during EMIT_*. A further accepted change waits until the FSM is in IDLE; it is never lost.
  - Untracked nonzero codes generate FIFO events only; they do not affect held or the pulses.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH. evt_valid = (evt_count ≠ 0).
  - A write when full with no pop in the same cycle drops the event and sets overflow.
  - Write and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Write and pop in the same cycle when empty: the write lands and the pop is ignored, because evt_valid was 0.
  - evt_ready while empty has no effect.
- A written event is visible on evt_valid/evt_data on the cycle after the write edge.

Test Plan:
1. Reset then idle: reset_n=0 for 2 cycles, keycode_in=0x00 → held=0x00, evt_valid=0, evt_count=0, overflow=0.
2. Press and release W, STABLE_CYCLES=4, evt_ready=0:
   - Apply keycode 0x1A → held[0]=1 four edges later; FIFO gets {1,0x1A}; press_pulse[0] high for exactly 1 cycle.
   - Then apply 0x00 → held=0x00; FIFO gets {0,0x1A}; evt_count=2.
3. Glitch reject: keycode 0x2C for 3 cycles, then 0x00 → no change to held, no events, no pulses.
4. Direct switch: accepted 0x04 (A), then 0x4F held 4 cycles → held goes 0x02→0x40.
   - Events are {0,0x04} then {1,0x4F} on consecutive edges.
   - release_pulse[1] and press_pulse[6] each fire once.
5. Overflow, FIFO_DEPTH=8, evt_ready=0: generate 9 events → evt_count=8, overflow=1, head evt_data = first event.
   - Pulse ovf_clr → overflow=0.
   - Then hold evt_ready=1 with a simultaneous write on full → count stays 8, overflow stays 0.
6. Untracked code and mid-operation reset:
   - Keycode 0x05 accepted → FIFO gets {1,0x05}, held=0x00.
   - Assert reset_n=0 in the EMIT_PRESS cycle → no event is written, all outputs return to 0.
